noc_endp_inject_arbiter: RTL and testbench
==========================================

NOC_ENDP_INJECT_ARBITER -- requirements
Module: noc_endp_inject_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4: number of requesters sharing one router local port (2..16).
REQ-002 SHALL have parameter Fw, default 32: flit payload width.
REQ-003 SHALL have parameter B, default 4: downstream buffer depth, i.e. the initial credit count (1..15).
REQ-004 SHALL have port clk  in  1  single clock; all state on its rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port req_wr  in  NREQ  per-requester flit-valid.
REQ-007 SHALL have port req_hdr  in  NREQ  per-requester head-flit marker.
REQ-008 SHALL have port req_tail  in  NREQ  per-requester tail-flit marker.
REQ-009 SHALL have port req_dat  in  NREQ*Fw  flit payloads; requester i occupies bits [(i+1)*Fw-1 : i*Fw].
REQ-010 SHALL have port req_ready  out  NREQ  flit accepted this cycle when req_wr[i] and req_ready[i] are both high.
REQ-011 SHALL have port out_wr, out_hdr, out_tail  out  1 each  registered flit strobe and markers toward the router.
REQ-012 SHALL have port out_dat  out  Fw  registered flit payload.
REQ-013 SHALL have port credit_in  in  1  one credit returned by the router per high cycle.
REQ-014 SHALL have port grant  out  NREQ  one-hot owner of the port; all-zero when idle.
REQ-015 SHALL have port hdr_err  out  1  one-cycle pulse on a protocol error.

Function
REQ-016 SHALL implement an FSM with states IDLE and LOCKED.
REQ-017 IDLE arbitration:
- Candidates are requesters with req_wr & req_hdr.
- Winner is chosen round-robin, starting at the index after the last packet owner.
REQ-018 Winner's head flit SHALL be accepted in the same cycle only if credit > 0; otherwise req_ready stays low and no state changes.
REQ-019 Accepted head without tail SHALL move the FSM to LOCKED, with grant = winner.
REQ-020 Head+tail (single-flit packet) SHALL keep the FSM in IDLE and advance the priority pointer.
REQ-021 In LOCKED, req_ready[owner] = (credit > 0); all other req_ready bits SHALL be 0.
REQ-022 Accepting the owner's tail flit SHALL return the FSM to IDLE, clear grant and set the pointer to owner+1, wrapping NREQ-1 -> 0.
REQ-023 An accepted flit SHALL appear on out_* exactly one cycle later; out_wr SHALL be low in every other cycle.
REQ-024 Credit counter (width clog2(B+1)):
- Decrement on accept; increment on credit_in.
- Both in the same cycle: unchanged.
- Never exceed B or go below 0.
REQ-025 A credit_in that would exceed B SHALL be ignored and SHALL pulse hdr_err.
REQ-026 Protocol errors:
- A non-head flit offered in IDLE is not accepted and pulses hdr_err.
- A head flit from the owner in LOCKED is not accepted and pulses hdr_err.
REQ-027 Non-owner requests SHALL be held (never dropped) until granted.

Reset
REQ-028 On reset low, immediately:
- FSM = IDLE, credit = B, pointer = 0.
- grant, req_ready, out_wr, out_hdr, out_tail, out_dat and hdr_err = 0.
REQ-029 Reset asserted mid-packet SHALL abandon the packet with no tail emitted; upstream reset is the system's responsibility.

Configuration
REQ-030 With NOC_INJ_ARB_STAT_EN defined:
- The module SHALL add output pkt_cnt  NREQ*16: per-requester saturating counters of completed packets (incremented on tail accept), reset to 0.
- It SHALL add input stat_clr, which synchronously zeroes all counters.
REQ-031 Without NOC_INJ_ARB_STAT_EN, those ports and counters SHALL be absent and behaviour SHALL be otherwise identical.

Structure
REQ-032 The FSM state enum and the credit-width function SHALL live in pronoc_pkg.
REQ-033 The round-robin selection SHALL be a sub-module arbiter_rr_onehot (request, pointer -> one-hot grant, combinational); the FSM, credit counter and output register SHALL stay in the top.

Verification
REQ-034 Reset: after reset release, grant=0, credit=4, out_wr=0, no req_ready with all req_wr=0.
REQ-035 Round-robin:
- Stimulus: requesters 0, 1, 3 each offer a 3-flit packet at once.
- Required: packets serialised in order 0, 1, 3; grant held for 3 accepted flits each; out_wr lags each accept by 1 cycle.
REQ-036 Credit stall:
- Stimulus: B=4, no credit_in, requester 2 sends a 6-flit packet.
- Required: 4 flits accepted, then req_ready[2]=0.
- Stimulus: two credit_in pulses.
- Required: flits 5-6 accepted and FSM returns to IDLE.
REQ-037 Simultaneous: accept and credit_in in the same cycle at credit=1 -> credit stays 1.
REQ-038 Protocol errors:
- Body flit from requester 1 in IDLE -> req_ready[1]=0, hdr_err pulses once.
- credit_in at credit=4 -> hdr_err pulses, credit stays 4.
REQ-039 Single-flit and stats:
- Stimulus: requesters 0 and 1 each send 2 head+tail flits with NOC_INJ_ARB_STAT_EN defined.
- Required: order 0, 1, 0, 1; pkt_cnt = 2 for each; stat_clr zeroes both.

Source files
------------

// File: rtl/pronoc_pkg.sv
// rtl/pronoc_pkg.sv - shared FSM type and credit-width helper for the injection arbiter
package pronoc_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } inj_state_e;

  // Bits needed to hold a credit count anywhere in 0..depth
  function automatic int credit_w(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/arbiter_rr_onehot.sv
// rtl/arbiter_rr_onehot.sv - combinational round-robin pick, first request at or after ptr wins
module arbiter_rr_onehot #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);

  int            scan;
  logic [PW-1:0] idx;
  logic          found;

  // Walk the requests starting at ptr, wrapping past N-1, and grant the first one seen
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    scan  = 0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      scan = int'(ptr) + i;
      if (scan >= N) scan = scan - N;
      idx = PW'(scan);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/noc_endp_inject_arbiter.sv
// rtl/noc_endp_inject_arbiter.sv - packet-locked credit-gated injection arbiter (stats: NOC_INJ_ARB_STAT_EN)
module noc_endp_inject_arbiter
  import pronoc_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int Fw   = 32,
  parameter int B    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_wr,
  input  logic [NREQ-1:0]   req_hdr,
  input  logic [NREQ-1:0]   req_tail,
  input  logic [NREQ*Fw-1:0] req_dat,
  output logic [NREQ-1:0]   req_ready,
  output logic              out_wr,
  output logic              out_hdr,
  output logic              out_tail,
  output logic [Fw-1:0]     out_dat,
  input  logic              credit_in,
  output logic [NREQ-1:0]   grant,
  output logic              hdr_err
`ifdef NOC_INJ_ARB_STAT_EN
  ,
  output logic [NREQ*16-1:0] pkt_cnt,
  input  logic               stat_clr
`endif
);

  localparam int              PW       = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int              CW       = credit_w(B);
  localparam logic [CW-1:0]   CR_MAX   = CW'(B);
  localparam logic [PW-1:0]   IDX_LAST = PW'(NREQ - 1);

  inj_state_e      state_q, state_d;
  logic [PW-1:0]   owner_q, ptr_q, win_idx, sel_idx, ptr_next;
  logic [CW-1:0]   credit_q;
  logic [NREQ-1:0] cand, arb_gnt;
  logic            credit_ok, accept, sel_hdr, sel_tail, proto_err, credit_ovf;
  logic [Fw-1:0]   sel_dat;

  assign cand      = req_wr & req_hdr;
  assign credit_ok = (credit_q != '0);
  assign accept    = |(req_wr & req_ready);
  assign ptr_next  = (sel_idx == IDX_LAST) ? '0 : sel_idx + 1'b1;

  arbiter_rr_onehot #(
    .N  (NREQ),
    .PW (PW)
  ) u_rr (
    .req (cand),
    .ptr (ptr_q),
    .gnt (arb_gnt)
  );

  // Convert the one-hot arbitration result to an index
  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NREQ; i++)
      if (arb_gnt[i]) win_idx = PW'(i);
  end

  // Select the flit of the requester that can be accepted this cycle
  always_comb begin
    sel_idx  = (state_q == ST_LOCKED) ? owner_q : win_idx;
    sel_hdr  = 1'b0;
    sel_tail = 1'b0;
    sel_dat  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (sel_idx == PW'(i)) begin
        sel_hdr  = req_hdr[i];
        sel_tail = req_tail[i];
        sel_dat  = req_dat[i*Fw +: Fw];
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state: lock on a multi-flit head, release on the owner's tail
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept && !sel_tail) state_d = ST_LOCKED;
      ST_LOCKED: if (accept && sel_tail)  state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: grant shows the owner; ready only where a flit may be taken
  always_comb begin
    grant     = '0;
    req_ready = '0;
    if (state_q == ST_LOCKED) begin
      grant[owner_q] = 1'b1;
      // A second head from the owner mid-packet is refused rather than merged
      req_ready[owner_q] = credit_ok & ~req_hdr[owner_q];
    end else if (credit_ok) begin
      req_ready = arb_gnt;
    end
  end

  // Protocol error detection: stray body flit while idle, or owner re-sending a head
  always_comb begin
    proto_err = 1'b0;
    if (state_q == ST_IDLE) proto_err = |(req_wr & ~req_hdr);
    else                    proto_err = req_wr[owner_q] & req_hdr[owner_q];
  end

  // A returned credit with the counter already full has nowhere to go
  assign credit_ovf = credit_in & ~accept & (credit_q == CR_MAX);

  // Owner and round-robin pointer: pointer moves past a requester once its packet ends
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_q <= '0;
      ptr_q   <= '0;
    end else if (accept) begin
      if (state_q == ST_IDLE) owner_q <= win_idx;
      if (sel_tail)           ptr_q   <= ptr_next;
    end
  end

  // Credit counter: accept consumes, credit_in returns, both together cancel
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      credit_q <= CR_MAX;
    end else if (accept && !credit_in) begin
      credit_q <= credit_q - 1'b1;
    end else if (!accept && credit_in && (credit_q != CR_MAX)) begin
      credit_q <= credit_q + 1'b1;
    end
  end

  // Output register: accepted flit appears exactly one cycle later
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_wr   <= 1'b0;
      out_hdr  <= 1'b0;
      out_tail <= 1'b0;
      out_dat  <= '0;
      hdr_err  <= 1'b0;
    end else begin
      out_wr   <= accept;
      out_hdr  <= accept & sel_hdr;
      out_tail <= accept & sel_tail;
      if (accept) out_dat <= sel_dat;
      hdr_err  <= proto_err | credit_ovf;
    end
  end

`ifdef NOC_INJ_ARB_STAT_EN
  // Per-requester completed-packet counters, saturating at all-ones
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pkt_cnt <= '0;
    end else if (stat_clr) begin
      pkt_cnt <= '0;
    end else if (accept && sel_tail) begin
      for (int i = 0; i < NREQ; i++)
        if ((sel_idx == PW'(i)) && (pkt_cnt[i*16 +: 16] != 16'hFFFF))
          pkt_cnt[i*16 +: 16] <= pkt_cnt[i*16 +: 16] + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_noc_endp_inject_arbiter.sv
// tb/tb_noc_endp_inject_arbiter.sv - scoreboard bench for the injection arbiter (stats checks with NOC_INJ_ARB_STAT_EN)
module tb_noc_endp_inject_arbiter;

  localparam int NREQ = 4;
  localparam int FW   = 32;
  localparam int B    = 4;

  typedef struct packed {
    logic [31:0] dat;
    logic        hdr;
    logic        tail;
  } flit_t;

  typedef struct packed {
    flit_t       f;
    logic [31:0] cyc;
  } exp_t;

  logic              clk;
  logic              reset;
  logic [NREQ-1:0]   req_wr, req_hdr, req_tail, req_ready, grant;
  logic [NREQ*FW-1:0] req_dat;
  logic              out_wr, out_hdr, out_tail, credit_in, hdr_err;
  logic [FW-1:0]     out_dat;
`ifdef NOC_INJ_ARB_STAT_EN
  logic [NREQ*16-1:0] pkt_cnt;
  logic               stat_clr;
`endif

  noc_endp_inject_arbiter #(.NREQ(NREQ), .Fw(FW), .B(B)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_wr    (req_wr),
    .req_hdr   (req_hdr),
    .req_tail  (req_tail),
    .req_dat   (req_dat),
    .req_ready (req_ready),
    .out_wr    (out_wr),
    .out_hdr   (out_hdr),
    .out_tail  (out_tail),
    .out_dat   (out_dat),
    .credit_in (credit_in),
    .grant     (grant),
    .hdr_err   (hdr_err)
`ifdef NOC_INJ_ARB_STAT_EN
    ,
    .pkt_cnt   (pkt_cnt),
    .stat_clr  (stat_clr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int err_seen = 0;

  flit_t       q [NREQ][$];
  exp_t        sb[$];
  int          errq[$];
  logic [7:0]  head_src[$];
  int          acc_log[$];

  int m_owner = -1;
  int m_ptr   = 0;
  int m_credit = B;
  int m_pkt [NREQ];
  int wr_pct = 100;
  int cr_pct = 100;
  int force_cr = 0;
  int pseq = 0;
  logic [NREQ-1:0] last_ready;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : mon
    exp_t e;
    logic exp_wr, exp_err;
    exp_wr = (sb.size() > 0) && (sb[0].cyc == 32'(cyc));
    chk("out_wr", 64'(out_wr), 64'(exp_wr));
    if (exp_wr) begin
      e = sb.pop_front();
      if (out_wr) begin
        chk("out_dat", 64'(out_dat), 64'(e.f.dat));
        chk("out_hdr", 64'(out_hdr), 64'(e.f.hdr));
        chk("out_tail", 64'(out_tail), 64'(e.f.tail));
      end
    end
    exp_err = (errq.size() > 0) && (errq[0] == cyc);
    if (exp_err) void'(errq.pop_front());
    chk("hdr_err", 64'(hdr_err), 64'(exp_err));
    if (hdr_err) err_seen++;
    if (out_wr && out_hdr) head_src.push_back(out_dat[31:24]);
  end

  task automatic add_pkt(input int r, input int len);
    flit_t f;
    for (int k = 0; k < len; k++) begin
      f.dat  = {8'(r), 8'(pseq), 8'(k), 8'($urandom)};
      f.hdr  = (k == 0);
      f.tail = (k == len - 1);
      q[r].push_back(f);
    end
    pseq++;
  endtask

  // One clock of stimulus plus reference-model evaluation
  task automatic cycle();
    logic [NREQ-1:0] er, eg;
    int   win, ai, idx;
    logic acc, err;
    req_wr = '0; req_hdr = '0; req_tail = '0; req_dat = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (q[i].size() > 0 && $urandom_range(99) < wr_pct) begin
        req_wr[i]   = 1'b1;
        req_hdr[i]  = q[i][0].hdr;
        req_tail[i] = q[i][0].tail;
        req_dat[i*FW +: FW] = q[i][0].dat;
      end
    end
    if (force_cr > 0) begin
      credit_in = 1'b1;
      force_cr--;
    end else begin
      credit_in = (m_credit < B) && ($urandom_range(99) < cr_pct);
    end
    @(negedge clk);
    er = '0; eg = '0; err = 1'b0; win = -1;
    if (m_owner < 0) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = (m_ptr + k) % NREQ;
        if (win < 0 && req_wr[idx] && req_hdr[idx]) win = idx;
      end
      if (win >= 0 && m_credit > 0) er[win] = 1'b1;
      for (int i = 0; i < NREQ; i++) if (req_wr[i] && !req_hdr[i]) err = 1'b1;
      ai = win;
    end else begin
      ai = m_owner;
      eg[m_owner] = 1'b1;
      if (m_credit > 0 && !req_hdr[m_owner]) er[m_owner] = 1'b1;
      if (req_wr[m_owner] && req_hdr[m_owner]) err = 1'b1;
    end
    acc = (ai >= 0) && er[ai] && req_wr[ai];
    chk("req_ready", 64'(req_ready), 64'(er));
    chk("grant", 64'(grant), 64'(eg));
    last_ready = req_ready;
    if (acc && !credit_in) m_credit--;
    else if (!acc && credit_in) begin
      if (m_credit < B) m_credit++;
      else err = 1'b1;
    end
    if (err) errq.push_back(cyc + 1);
`ifdef NOC_INJ_ARB_STAT_EN
    if (stat_clr) for (int i = 0; i < NREQ; i++) m_pkt[i] = 0;
    else if (acc && q[ai][0].tail) m_pkt[ai]++;
`endif
    if (acc) begin
      sb.push_back({q[ai][0], 32'(cyc + 1)});
      acc_log.push_back(ai);
      if (q[ai][0].tail) begin
        m_owner = -1;
        m_ptr   = (ai + 1) % NREQ;
      end else if (m_owner < 0) begin
        m_owner = ai;
      end
    end
    @(posedge clk);
    #1;
    if (acc) void'(q[ai].pop_front());
  endtask

  function automatic logic busy();
    logic b;
    b = (sb.size() > 0) || (m_owner >= 0);
    for (int i = 0; i < NREQ; i++) if (q[i].size() > 0) b = 1'b1;
    return b;
  endfunction

  task automatic run_until_idle(input int budget);
    int k;
    k = 0;
    while (busy() && k < budget) begin
      cycle();
      k++;
    end
    chk("drain_busy", 64'(busy()), 64'(0));
  endtask

  task automatic refill();
    cr_pct = 100;
    for (int k = 0; k < 20 && m_credit < B; k++) cycle();
  endtask

  task automatic model_reset();
    m_owner = -1; m_ptr = 0; m_credit = B;
    for (int i = 0; i < NREQ; i++) begin
      m_pkt[i] = 0;
      q[i].delete();
    end
    sb.delete();
    errq.delete();
  endtask

  initial begin : stim
    logic [63:0] v;
    flit_t bad;
    int e0;
    reset = 1'b1; credit_in = 1'b0;
    req_wr = '0; req_hdr = '0; req_tail = '0; req_dat = '0;
`ifdef NOC_INJ_ARB_STAT_EN
    stat_clr = 1'b0;
`endif
    model_reset();
    #2 reset = 1'b0;
    #1;
    chk("rst_out_wr", 64'(out_wr), 64'(0));
    chk("rst_grant", 64'(grant), 64'(0));
    chk("rst_hdr_err", 64'(hdr_err), 64'(0));
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    repeat (2) cycle();
    chk("rst_ready", 64'(last_ready), 64'(0));

    // Round-robin across three 3-flit packets
    head_src.delete(); acc_log.delete();
    wr_pct = 100; cr_pct = 100;
    add_pkt(0, 3); add_pkt(1, 3); add_pkt(3, 3);
    run_until_idle(200);
    v = 0;
    foreach (head_src[k]) v = {v[55:0], head_src[k]};
    chk("rr_head_order", v, 64'h000103);
    v = 0;
    foreach (acc_log[k]) v = {v[59:0], 4'(acc_log[k])};
    chk("rr_accept_seq", v, 64'h111333);

    // Single-flit packets and statistics
    head_src.delete();
    add_pkt(0, 1); add_pkt(0, 1); add_pkt(1, 1); add_pkt(1, 1);
    run_until_idle(100);
    v = 0;
    foreach (head_src[k]) v = {v[55:0], head_src[k]};
    chk("sf_head_order", v, 64'h00010001);
`ifdef NOC_INJ_ARB_STAT_EN
    chk("pkt_cnt0", 64'(pkt_cnt[15:0]), 64'd2);
    chk("pkt_cnt1", 64'(pkt_cnt[31:16]), 64'd2);
    stat_clr = 1'b1;
    cycle();
    stat_clr = 1'b0;
    chk("pkt_cnt0_clr", 64'(pkt_cnt[15:0]), 64'd0);
    chk("pkt_cnt1_clr", 64'(pkt_cnt[31:16]), 64'd0);
`endif

    // Credit overflow at a full counter
    refill();
    cr_pct = 0;
    e0 = err_seen;
    force_cr = 1;
    cycle(); cycle(); cycle();
    chk("ovf_err_pulses", 64'(err_seen - e0), 64'd1);

    // Credit stall: only B flits fit, then two returned credits finish the packet
    acc_log.delete();
    add_pkt(2, 6);
    repeat (8) cycle();
    chk("stall_acc", 64'(acc_log.size()), 64'd4);
    chk("stall_ready2", 64'(last_ready[2]), 64'd0);
    force_cr = 2;
    cycle();
    chk("cr0_ready2", 64'(last_ready[2]), 64'd0);
    cycle();
    cycle();
    chk("simul_keeps_credit", 64'(last_ready[2]), 64'd1);
    chk("stall_acc_total", 64'(acc_log.size()), 64'd6);
    chk("stall_idle_grant", 64'(grant), 64'd0);

    // Body flit offered while idle
    refill();
    e0 = err_seen;
    bad.dat = 32'hDEAD0001; bad.hdr = 1'b0; bad.tail = 1'b0;
    q[1].push_back(bad);
    cycle();
    chk("body_idle_ready1", 64'(last_ready[1]), 64'd0);
    q[1].delete();
    cycle(); cycle();
    chk("body_idle_err", 64'(err_seen - e0), 64'd1);

    // Owner re-sends a head mid-packet
    add_pkt(0, 3);
    for (int k = 0; k < 10 && m_owner != 0; k++) cycle();
    e0 = err_seen;
    bad.dat = 32'hDEAD0002; bad.hdr = 1'b1; bad.tail = 1'b0;
    q[0].push_front(bad);
    cycle();
    chk("owner_hdr_ready0", 64'(last_ready[0]), 64'd0);
    void'(q[0].pop_front());
    run_until_idle(100);
    chk("owner_hdr_err", 64'(err_seen - e0), 64'd1);

    // Randomised traffic with random valid gaps and credit return
    wr_pct = 70; cr_pct = 50;
    for (int p = 0; p < 30; p++) add_pkt($urandom_range(NREQ - 1), $urandom_range(5, 1));
    run_until_idle(3000);
`ifdef NOC_INJ_ARB_STAT_EN
    for (int i = 0; i < NREQ; i++) chk("pkt_cnt_rand", 64'(pkt_cnt[i*16 +: 16]), 64'(m_pkt[i]));
`endif

    // Asynchronous reset in the middle of a packet
    wr_pct = 100;
    refill();
    add_pkt(3, 5);
    repeat (3) cycle();
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_out_wr", 64'(out_wr), 64'(0));
    chk("mid_rst_grant", 64'(grant), 64'(0));
    chk("mid_rst_ready", 64'(req_ready), 64'(0));
    model_reset();
    req_wr = '0; req_hdr = '0; req_tail = '0; credit_in = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    add_pkt(2, 1);
    run_until_idle(50);
    chk("post_rst_grant", 64'(grant), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

  initial begin : watchdog
    #400000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
